// File: rtl/servo_pot_ctrl.sv
// servo_pot_ctrl
//   Closes the position loop between an 8-bit target pot code and the servo
//   potentiometer, sampled once per PWM period through an external ADC, and
//   drives a direction-gated proportional PWM into the motor H-bridge.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous reset, active-low
//   target       target pot code (unsigned)
//   target_valid upstream reference is in range
//   adc_start    one-cycle conversion request pulse (registered)
//   adc_done     one-cycle conversion-complete pulse, adc_data valid with it
//   adc_data     measured pot code (unsigned)
//   motor_fwd    forward drive, PWM gated by direction
//   motor_rev    reverse drive, PWM gated by direction
//   at_pos       position within the deadband (registered)
//   fault        sticky ADC-timeout flag, cleared only by rst_n
module servo_pot_ctrl #(
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned DEADBAND    = 2,
  parameter int unsigned KP_SHIFT    = 2,
  parameter int unsigned MIN_DUTY    = 32,
  parameter int unsigned ADC_TIMEOUT = 1023
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] target,
  input  logic       target_valid,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic       motor_fwd,
  output logic       motor_rev,
  output logic       at_pos,
  output logic       fault
);

  localparam int unsigned TW         = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned DUTY_MAX_I = (1 << PWM_BITS) - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL
  } state_t;

  state_t              state;
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS-1:0] live_duty;
  logic [PWM_BITS-1:0] shadow_duty;
  logic                live_fwd;
  logic                live_rev;
  logic                shadow_fwd;
  logic                shadow_rev;
  logic [TW-1:0]       tcnt;
  logic [7:0]          adc_q;

  // Evaluation datapath (consumed only in S_EVAL)
  logic [8:0]          err;
  logic [7:0]          mag;
  logic [31:0]         scaled;
  logic [PWM_BITS-1:0] duty_sat;
  logic [PWM_BITS-1:0] eval_duty;
  logic                eval_fwd;
  logic                eval_rev;
  logic                eval_at;

  logic wrap;
  logic pwm;

  assign wrap = (cnt == '1);
  assign pwm  = (cnt < live_duty);

  // Direction registers are one-hot-or-zero, so the two drives can never
  // be high together.
  assign motor_fwd = pwm & live_fwd;
  assign motor_rev = pwm & live_rev;

  always_comb begin
    err      = {1'b0, target} - {1'b0, adc_q};
    mag      = 8'(err[8] ? -err : err);
    scaled   = 32'(mag) << KP_SHIFT;
    duty_sat = (scaled > DUTY_MAX_I) ? PWM_BITS'(DUTY_MAX_I) : PWM_BITS'(scaled);

    eval_duty = '0;
    eval_fwd  = 1'b0;
    eval_rev  = 1'b0;
    eval_at   = 1'b0;

    if (!target_valid || fault) begin
      eval_at = 1'b0;
    end else if (32'(mag) <= DEADBAND) begin
      eval_at = 1'b1;
    end else begin
      eval_duty = (duty_sat < PWM_BITS'(MIN_DUTY)) ? PWM_BITS'(MIN_DUTY) : duty_sat;
      eval_fwd  = ~err[8];
      eval_rev  = err[8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      live_duty   <= '0;
      shadow_duty <= '0;
      live_fwd    <= 1'b0;
      live_rev    <= 1'b0;
      shadow_fwd  <= 1'b0;
      shadow_rev  <= 1'b0;
      tcnt        <= '0;
      adc_q       <= '0;
      adc_start   <= 1'b0;
      at_pos      <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cnt       <= cnt + 1'b1;
      adc_start <= 1'b0;

      // Shadow -> live only on the wrap cycle keeps every period intact.
      if (wrap) begin
        live_duty <= shadow_duty;
        live_fwd  <= shadow_fwd;
        live_rev  <= shadow_rev;
      end

      case (state)
        S_IDLE: begin
          if (cnt == '0) begin
            state     <= S_REQ;
            adc_start <= 1'b1;
          end
        end
        S_REQ: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (adc_done) begin
            adc_q <= adc_data;
            state <= S_EVAL;
          end else if (tcnt == TW'(ADC_TIMEOUT - 1)) begin
            // Timeout overrides the wrap load above so the motor stops now,
            // not at the next period boundary.
            fault       <= 1'b1;
            shadow_duty <= '0;
            shadow_fwd  <= 1'b0;
            shadow_rev  <= 1'b0;
            live_duty   <= '0;
            live_fwd    <= 1'b0;
            live_rev    <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_EVAL: begin
          shadow_duty <= eval_duty;
          shadow_fwd  <= eval_fwd;
          shadow_rev  <= eval_rev;
          at_pos      <= eval_at;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pot_ctrl.sv
module tb_servo_pot_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] target = 8'd100;
  logic       target_valid = 1'b1;
  logic       adc_start;
  logic       adc_done;
  logic [7:0] adc_data = 8'd80;
  logic       motor_fwd;
  logic       motor_rev;
  logic       at_pos;
  logic       fault;

  logic       resp_done = 1'b0;
  logic       stray_done = 1'b0;
  bit         adc_en = 1'b1;
  int         pend = 0;
  logic [7:0] mcnt;

  int checks = 0;
  int errors = 0;

  servo_pot_ctrl #(
    .PWM_BITS(8),
    .DEADBAND(2),
    .KP_SHIFT(2),
    .MIN_DUTY(32),
    .ADC_TIMEOUT(1023)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .target(target),
    .target_valid(target_valid),
    .adc_start(adc_start),
    .adc_done(adc_done),
    .adc_data(adc_data),
    .motor_fwd(motor_fwd),
    .motor_rev(motor_rev),
    .at_pos(at_pos),
    .fault(fault)
  );

  always #5 clk = ~clk;

  assign adc_done = resp_done | stray_done;

  // Reference PWM counter position
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 8'd0;
    else        mcnt <= mcnt + 8'd1;
  end

  // ADC model: done pulse 5 cycles after each observed start pulse
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      = 0;
      resp_done = 1'b0;
    end else begin
      resp_done = 1'b0;
      if (pend != 0) begin
        pend = pend - 1;
        if (pend == 0) resp_done = 1'b1;
      end else if (adc_start && adc_en) begin
        pend = 5;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Observes one full PWM period starting at the next counter zero.
  task automatic check_period(input int efwd, input int erev, input logic eat, input string tag);
    int guard = 0;
    int fh = 0, rh = 0, both = 0, bad = 0, starts = 0, sbad = 0;
    logic atp = 1'bx;
    while (mcnt != 8'd0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".sync"}, 32'(guard < 300), 32'd1);
    for (int i = 0; i < 256; i++) begin
      if (motor_fwd === 1'b1) fh++;
      if (motor_rev === 1'b1) rh++;
      if (motor_fwd === 1'b1 && motor_rev === 1'b1) both++;
      if (motor_fwd !== logic'(i < efwd) || motor_rev !== logic'(i < erev)) bad++;
      if (adc_start === 1'b1) begin
        starts++;
        if (i != 1) sbad++;
      end
      if (i == 200) atp = at_pos;
      @(negedge clk);
    end
    chk({tag, ".fwd_cycles"}, 32'(fh), 32'(efwd));
    chk({tag, ".rev_cycles"}, 32'(rh), 32'(erev));
    chk({tag, ".overlap"}, 32'(both), 32'd0);
    chk({tag, ".pattern"}, 32'(bad), 32'd0);
    chk({tag, ".start"}, 32'(starts == 1 && sbad == 0), 32'd1);
    chk({tag, ".at_pos"}, 32'(atp), 32'(eat));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst.adc_start", 32'(adc_start), 32'd0);
    chk("rst.motor_fwd", 32'(motor_fwd), 32'd0);
    chk("rst.motor_rev", 32'(motor_rev), 32'd0);
    chk("rst.at_pos", 32'(at_pos), 32'd0);
    chk("rst.fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    // target 100, adc 80 -> err 20, duty 80 forward from the next period
    check_period(0, 0, 1'b0, "p0");
    check_period(80, 0, 1'b0, "p1");

    // 0x10 vs 0xF0 -> err -224, saturated reverse; reversal only at boundary
    target   = 8'h10;
    adc_data = 8'hF0;
    check_period(80, 0, 1'b0, "p2");
    check_period(0, 255, 1'b0, "p3");

    // Within deadband
    target   = 8'd100;
    adc_data = 8'd99;
    check_period(0, 255, 1'b1, "p4");

    // Invalid target forces off and clears at_pos
    target_valid = 1'b0;
    check_period(0, 0, 1'b0, "p5");

    // err 3 -> 12, floored to 32
    target_valid = 1'b1;
    adc_data     = 8'd97;
    check_period(0, 0, 1'b0, "p6");
    check_period(32, 0, 1'b0, "p7");

    // Target changes mid-conversion: EVAL-cycle value 150 gives err 53 -> 212
    repeat (3) @(negedge clk);
    target = 8'd150;
    check_period(212, 0, 1'b0, "p9");

    // Asynchronous reset mid-WAIT while the motor is driven
    repeat (3) @(negedge clk);
    chk("midwait.pre_fwd", 32'(motor_fwd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst.motor_fwd", 32'(motor_fwd), 32'd0);
    chk("arst.motor_rev", 32'(motor_rev), 32'd0);
    chk("arst.adc_start", 32'(adc_start), 32'd0);
    chk("arst.at_pos", 32'(at_pos), 32'd0);
    chk("arst.fault", 32'(fault), 32'd0);
    @(negedge clk);
    target     = 8'd100;
    adc_data   = 8'd0;
    stray_done = 1'b1;
    rst_n      = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    adc_data   = 8'd80;
    chk("arst.start_after", 32'(adc_start), 32'd1);
    check_period(80, 0, 1'b0, "q1");

    // ADC never answers -> fault, immediate motor stop
    adc_en = 1'b0;
    repeat (1000) @(negedge clk);
    chk("to.fault_early", 32'(fault), 32'd0);
    repeat (40) @(negedge clk);
    chk("to.fault", 32'(fault), 32'd1);
    chk("to.motor_fwd", 32'(motor_fwd), 32'd0);
    chk("to.motor_rev", 32'(motor_rev), 32'd0);
    adc_en = 1'b1;
    check_period(0, 0, 1'b0, "q7");
    check_period(0, 0, 1'b0, "q8");
    chk("to.sticky", 32'(fault), 32'd1);

    rst_n = 1'b0;
    #1;
    chk("to.rst_clear", 32'(fault), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
